stream_demux2: RTL and testbench

STREAM_DEMUX2 -- requirements
Module: stream_demux2

---
 rtl/lab_pkg.sv | 8 +
 rtl/demux_fifo2.sv | 58 +++++
 rtl/stream_demux2.sv | 77 +++++++
 tb/tb_stream_demux2.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/lab_pkg.sv
// Shared constants for the two-way stream demultiplexer.
// Holds the default widths and the per-port buffer depth.
package lab_pkg;
   localparam int W_DEF      = 8;
   localparam int CW_DEF     = 8;
   localparam int FIFO_DEPTH = 2;
   localparam int FIFO_CNT_W = $clog2(FIFO_DEPTH + 1);
endpackage : lab_pkg

// File: rtl/demux_fifo2.sv
// Two-entry shifting FIFO: entry 0 is always the head, so the output needs no read mux.
// Push is ignored when full and pop is ignored when empty.
module demux_fifo2
   import lab_pkg::*;
#(
   parameter int W = W_DEF
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push_i,
   input  logic [W-1:0] din_i,
   input  logic         pop_i,
   output logic         full_o,
   output logic         empty_o,
   output logic [W-1:0] head_o
);

   logic [W-1:0]          ent_q [FIFO_DEPTH];
   logic [W-1:0]          ent_d [FIFO_DEPTH];
   logic [FIFO_CNT_W-1:0] count_q, count_d;
   logic [FIFO_CNT_W-1:0] wr_pos;
   logic                  do_push, do_pop;

   assign full_o  = (count_q == FIFO_CNT_W'(FIFO_DEPTH));
   assign empty_o = (count_q == '0);
   assign head_o  = ent_q[0];

   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;

   // A pop shifts entry 1 forward first; the push then lands behind whatever remains.
   assign wr_pos = count_q - FIFO_CNT_W'(do_pop);

   always_comb begin
      ent_d[0] = ent_q[0];
      ent_d[1] = ent_q[1];
      count_d  = count_q + FIFO_CNT_W'(do_push) - FIFO_CNT_W'(do_pop);
      if (do_pop) begin
         ent_d[0] = ent_q[1];
      end
      if (do_push) begin
         ent_d[wr_pos[0]] = din_i;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q  <= '0;
         ent_q[0] <= '0;
         ent_q[1] <= '0;
      end else begin
         count_q  <= count_d;
         ent_q[0] <= ent_d[0];
         ent_q[1] <= ent_d[1];
      end
   end

endmodule : demux_fifo2

// File: rtl/stream_demux2.sv
// Routes one valid/ready input stream to two independently buffered output ports.
// Ready depends only on the selected FIFO's occupancy, never on the consumers' ready.
module stream_demux2
   import lab_pkg::*;
#(
   parameter int W  = W_DEF,
   parameter int CW = CW_DEF
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [W-1:0]  in_data,
   input  logic          in_sel,
   output logic          out0_valid,
   input  logic          out0_ready,
   output logic [W-1:0]  out0_data,
   output logic          out1_valid,
   input  logic          out1_ready,
   output logic [W-1:0]  out1_data,
   output logic [CW-1:0] cnt0,
   output logic [CW-1:0] cnt1
);

   logic          full0, full1, empty0, empty1;
   logic          push0, push1, xfer;
   logic [CW-1:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;

   assign in_ready = !rst && (in_sel ? !full1 : !full0);
   assign xfer     = in_valid && in_ready;
   assign push0    = xfer && !in_sel;
   assign push1    = xfer &&  in_sel;

   demux_fifo2 #(.W(W)) u_fifo0 (
      .clk     (clk),
      .rst     (rst),
      .push_i  (push0),
      .din_i   (in_data),
      .pop_i   (out0_ready),
      .full_o  (full0),
      .empty_o (empty0),
      .head_o  (out0_data)
   );

   demux_fifo2 #(.W(W)) u_fifo1 (
      .clk     (clk),
      .rst     (rst),
      .push_i  (push1),
      .din_i   (in_data),
      .pop_i   (out1_ready),
      .full_o  (full1),
      .empty_o (empty1),
      .head_o  (out1_data)
   );

   assign out0_valid = !empty0;
   assign out1_valid = !empty1;

   always_comb begin
      cnt0_d = cnt0_q + CW'(push0);
      cnt1_d = cnt1_q + CW'(push1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt0_q <= '0;
         cnt1_q <= '0;
      end else begin
         cnt0_q <= cnt0_d;
         cnt1_q <= cnt1_d;
      end
   end

   assign cnt0 = cnt0_q;
   assign cnt1 = cnt1_q;

endmodule : stream_demux2

// File: tb/tb_stream_demux2.sv
// Randomized and directed bench for stream_demux2 against a queue-based reference model.
module tb_stream_demux2;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [7:0] in_data = 8'h00;
   logic       in_sel = 1'b0;
   logic       out0_valid, out1_valid;
   logic       out0_ready = 1'b0;
   logic       out1_ready = 1'b0;
   logic [7:0] out0_data, out1_data;
   logic [7:0] cnt0, cnt1;

   int n_chk = 0;
   int n_err = 0;

   logic [7:0] q0[$];
   logic [7:0] q1[$];
   logic [7:0] m_cnt0 = 8'd0;
   logic [7:0] m_cnt1 = 8'd0;
   bit         zero0 = 1'b1;
   bit         zero1 = 1'b1;

   always #5 clk = ~clk;

   stream_demux2 #(.W(8), .CW(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .in_sel     (in_sel),
      .out0_valid (out0_valid),
      .out0_ready (out0_ready),
      .out0_data  (out0_data),
      .out1_valid (out1_valid),
      .out1_ready (out1_ready),
      .out1_data  (out1_data),
      .cnt0       (cnt0),
      .cnt1       (cnt1)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic check_outs();
      chk("out0_valid", {31'd0, out0_valid}, {31'd0, q0.size() > 0});
      if (q0.size() > 0)  chk("out0_data", {24'd0, out0_data}, {24'd0, q0[0]});
      else if (zero0)     chk("out0_data_rst", {24'd0, out0_data}, 32'd0);
      chk("out1_valid", {31'd0, out1_valid}, {31'd0, q1.size() > 0});
      if (q1.size() > 0)  chk("out1_data", {24'd0, out1_data}, {24'd0, q1[0]});
      else if (zero1)     chk("out1_data_rst", {24'd0, out1_data}, 32'd0);
      chk("cnt0", {24'd0, cnt0}, {24'd0, m_cnt0});
      chk("cnt1", {24'd0, cnt1}, {24'd0, m_cnt1});
   endtask

   // One clock cycle: drive at the falling edge, check ready, advance the model, check outputs.
   task automatic step(input logic v, input logic s, input logic [7:0] d,
                       input logic r0, input logic r1, input logic rs, output logic rdy);
      logic exp_rdy, pop0, pop1;
      in_valid = v; in_sel = s; in_data = d;
      out0_ready = r0; out1_ready = r1; rst = rs;
      #1;
      exp_rdy = !rs && ((s ? q1.size() : q0.size()) < 2);
      chk("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
      rdy = in_ready;
      if (rs) begin
         q0.delete(); q1.delete();
         m_cnt0 = 8'd0; m_cnt1 = 8'd0;
         zero0 = 1'b1; zero1 = 1'b1;
      end else begin
         pop0 = r0 && (q0.size() > 0);
         pop1 = r1 && (q1.size() > 0);
         if (pop0) void'(q0.pop_front());
         if (pop1) void'(q1.pop_front());
         if (v && exp_rdy) begin
            if (s) begin q1.push_back(d); m_cnt1 = m_cnt1 + 8'd1; zero1 = 1'b0; end
            else   begin q0.push_back(d); m_cnt0 = m_cnt0 + 8'd1; zero0 = 1'b0; end
         end
      end
      @(negedge clk);
      check_outs();
   endtask

   initial begin
      logic r;
      @(negedge clk);
      step(0, 0, 8'h00, 0, 0, 1, r);
      step(0, 0, 8'h00, 0, 0, 1, r);

      // single word to port 0
      step(1, 0, 8'hA5, 1, 0, 0, r);
      chk("single_valid0", {31'd0, out0_valid}, 32'd1);
      chk("single_data0", {24'd0, out0_data}, 32'hA5);
      chk("single_valid1", {31'd0, out1_valid}, 32'd0);
      chk("single_cnt0", {24'd0, cnt0}, 32'd1);
      step(0, 0, 8'h00, 1, 0, 0, r);

      // backpressure on port 1
      step(1, 1, 8'h11, 0, 0, 0, r);
      step(1, 1, 8'h22, 0, 0, 0, r);
      step(1, 1, 8'h33, 0, 0, 0, r);
      chk("bp_ready_full", {31'd0, r}, 32'd0);
      step(1, 1, 8'h33, 0, 1, 0, r);
      chk("bp_ready_pop", {31'd0, r}, 32'd0);
      chk("bp_head22", {24'd0, out1_data}, 32'h22);
      step(1, 1, 8'h33, 0, 1, 0, r);
      chk("bp_ready_after", {31'd0, r}, 32'd1);
      chk("bp_head33", {24'd0, out1_data}, 32'h33);
      step(0, 1, 8'h00, 0, 1, 0, r);
      chk("bp_drained", {31'd0, out1_valid}, 32'd0);

      // port 0 full and stalled, port 1 still accepts
      step(1, 0, 8'h01, 0, 0, 0, r);
      step(1, 0, 8'h02, 0, 0, 0, r);
      step(1, 1, 8'h44, 0, 0, 0, r);
      chk("indep_ready", {31'd0, r}, 32'd1);
      chk("indep_data1", {24'd0, out1_data}, 32'h44);

      // full port 0 popped: push refused this cycle, accepted next
      step(1, 0, 8'h55, 1, 0, 0, r);
      chk("fullpop_ready", {31'd0, r}, 32'd0);
      step(1, 0, 8'h55, 0, 0, 0, r);
      chk("fullpop_next", {31'd0, r}, 32'd1);

      // mid-operation reset with both FIFOs occupied
      step(0, 0, 8'h00, 0, 0, 1, r);
      chk("rst_ready", {31'd0, r}, 32'd0);
      chk("rst_v0", {31'd0, out0_valid}, 32'd0);
      chk("rst_v1", {31'd0, out1_valid}, 32'd0);
      chk("rst_c0", {24'd0, cnt0}, 32'd0);
      chk("rst_c1", {24'd0, cnt1}, 32'd0);
      for (int i = 0; i < 4; i++) step(0, 0, 8'h00, 1, 1, 0, r);

      // counter wrap on port 0
      for (int i = 1; i <= 256; i++) begin
         step(1, 0, 8'(i), 1, 0, 0, r);
         if (i == 255) chk("wrap_255", {24'd0, cnt0}, 32'd255);
         if (i == 256) chk("wrap_0", {24'd0, cnt0}, 32'd0);
      end
      step(0, 0, 8'h00, 1, 0, 0, r);

      // randomized traffic with phase-varying consumer pressure
      for (int i = 0; i < 3000; i++) begin
         int bias;
         bias = (i / 500) % 3;
         step($urandom_range(0, 3) != 0, 1'($urandom), 8'($urandom),
              $urandom_range(0, 2) < bias + 1 ? 1'b1 : 1'b0,
              $urandom_range(0, 2) < 3 - bias ? 1'b1 : 1'b0,
              $urandom_range(0, 149) == 0, r);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule : tb_stream_demux2
